// File: rtl/sh2_irl_encoder.sv
// IRL encoder / external vector responder facing the SH7604 INTC.
// Define IRLENC_LEVEL_SRC_EN for level-sensitive sources (default: edge-latched).
module sh2_irl_encoder #(
  parameter int          NUM_SRC  = 8,
  parameter int          GAP_CYC  = 6,
  parameter logic [7:0]  SPUR_VEC = 8'h18
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE,
  input  logic [NUM_SRC-1:0]     SRC_IRQ,
  input  logic [NUM_SRC-1:0]     SRC_CLR,
  input  logic [4*NUM_SRC-1:0]   SRC_LVL,
  input  logic [8*NUM_SRC-1:0]   SRC_VEC,
  output logic [3:0]             IRL_N,
  input  logic [3:0]             VBUS_A,
  input  logic                   VBUS_REQ,
  output logic [7:0]             VBUS_DI,
  output logic                   VBUS_WAIT,
  output logic                   BUSY
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RESP,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [NUM_SRC-1:0] r_irq_s;
  logic [IW-1:0]    r_cur_idx;
  logic [IW-1:0]    w_nxt_idx;
  logic [3:0]       r_cur_lvl;
  logic [3:0]       w_nxt_lvl;
  logic [7:0]       r_vdi;
  logic [7:0]       w_nxt_vdi;
  logic             r_match;
  logic             w_nxt_match;
  logic             r_drv;
  logic             w_nxt_drv;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_nxt_cnt;
  logic [3:0]       r_irl;
  logic [3:0]       w_nxt_irl;

  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_keep;
  logic [IW-1:0]    w_cand_idx;
  logic [3:0]       w_cand_lvl;
  logic             w_has_cand;
  logic [7:0]       w_cur_vec;
  logic             w_cur_drop;
  logic             w_vmatch;

`ifdef IRLENC_LEVEL_SRC_EN
  assign w_pend = r_irq_s;
  assign w_keep = r_irq_s;
`else
  logic [NUM_SRC-1:0] r_irq_d;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_served;

  assign w_rise = r_irq_s & ~r_irq_d;
  assign w_pend = r_pend;
  // Pending bits surviving this cycle, ignoring a fetch completion.
  assign w_keep = (r_pend & ~SRC_CLR) | w_rise;

  always_comb begin
    w_served = '0;
    if (r_state == S_RESP && !VBUS_REQ && r_match) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (IW'(i) == r_cur_idx) w_served[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_irq_d <= '0;
      r_pend  <= '0;
    end else if (CE) begin
      r_irq_d <= r_irq_s;
      r_pend  <= (r_pend & ~SRC_CLR & ~w_served) | w_rise;
    end
  end
`endif

  // Highest level wins; strict compare keeps the lowest index on ties.
  always_comb begin
    w_cand_idx = '0;
    w_cand_lvl = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_pend[i] && SRC_LVL[4*i +: 4] > w_cand_lvl) begin
        w_cand_lvl = SRC_LVL[4*i +: 4];
        w_cand_idx = IW'(i);
      end
    end
  end

  assign w_has_cand = (w_cand_lvl != 4'd0);

  always_comb begin
    w_cur_vec  = '0;
    w_cur_drop = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (IW'(i) == r_cur_idx) begin
        w_cur_vec  = SRC_VEC[8*i +: 8];
        w_cur_drop = ~w_keep[i];
      end
    end
  end

  assign w_vmatch = (VBUS_A == r_cur_lvl);

  always_comb begin
    w_nxt       = r_state;
    w_nxt_idx   = r_cur_idx;
    w_nxt_lvl   = r_cur_lvl;
    w_nxt_vdi   = r_vdi;
    w_nxt_match = r_match;
    w_nxt_drv   = r_drv;
    w_nxt_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (VBUS_REQ) begin
          w_nxt       = S_RESP;
          w_nxt_vdi   = SPUR_VEC;
          w_nxt_match = 1'b0;
          w_nxt_drv   = 1'b0;
        end else if (w_has_cand) begin
          w_nxt     = S_DRIVE;
          w_nxt_idx = w_cand_idx;
          w_nxt_lvl = w_cand_lvl;
        end
      end
      S_DRIVE: begin
        if (VBUS_REQ) begin
          w_nxt       = S_RESP;
          w_nxt_match = w_vmatch;
          w_nxt_vdi   = w_vmatch ? w_cur_vec : SPUR_VEC;
          w_nxt_drv   = 1'b1;
        end else if (w_has_cand && w_cand_lvl > r_cur_lvl) begin
          w_nxt_idx = w_cand_idx;
          w_nxt_lvl = w_cand_lvl;
        end else if (w_cur_drop) begin
          w_nxt     = S_GAP;
          w_nxt_cnt = CW'(GAP_CYC - 1);
        end
      end
      S_RESP: begin
        if (!VBUS_REQ) begin
          if (r_match) begin
            w_nxt     = S_GAP;
            w_nxt_cnt = CW'(GAP_CYC - 1);
          end else if (r_drv) begin
            w_nxt = S_DRIVE;
          end else begin
            w_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (VBUS_REQ) begin
          w_nxt       = S_RESP;
          w_nxt_vdi   = SPUR_VEC;
          w_nxt_match = 1'b0;
          w_nxt_drv   = 1'b0;
        end else if (r_cnt == '0) begin
          w_nxt = S_IDLE;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // IRL is registered from the next state so it never glitches.
  always_comb begin
    w_nxt_irl = 4'hF;
    if (w_nxt == S_DRIVE || (w_nxt == S_RESP && w_nxt_drv)) begin
      w_nxt_irl = ~w_nxt_lvl;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_irq_s   <= '0;
      r_cur_idx <= '0;
      r_cur_lvl <= '0;
      r_vdi     <= 8'h00;
      r_match   <= 1'b0;
      r_drv     <= 1'b0;
      r_cnt     <= '0;
      r_irl     <= 4'hF;
    end else if (CE) begin
      r_state   <= w_nxt;
      r_irq_s   <= SRC_IRQ;
      r_cur_idx <= w_nxt_idx;
      r_cur_lvl <= w_nxt_lvl;
      r_vdi     <= w_nxt_vdi;
      r_match   <= w_nxt_match;
      r_drv     <= w_nxt_drv;
      r_cnt     <= w_nxt_cnt;
      r_irl     <= w_nxt_irl;
    end
  end

  assign IRL_N     = r_irl;
  assign VBUS_DI   = r_vdi;
  assign VBUS_WAIT = VBUS_REQ & (r_state != S_RESP);
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: doc/sh2_irl_encoder.md
# sh2_irl_encoder

External interrupt encoder/responder on the SH7604 IRL side: it collects up to NUM_SRC peripheral interrupt sources and arbitrates them by programmed level. It drives the winning level onto IRL_N and answers the CPU's external vector fetch on the VBUS (VBUS_A/VBUS_REQ → VBUS_DI/VBUS_WAIT). It sits outside the CPU core, facing the INTC, and is the device-side end of the IRL / vector-fetch protocol.

## Interface
- NUM_SRC, 8: number of sources (1..16).
- GAP_CYC, 6: CE-qualified cycles IRL_N is held at 4'hF after a served interrupt. Must be ≥5 so the INTC's 4-deep stability filter sees deassertion.
- SPUR_VEC, 8'h18: vector returned when VBUS_A does not match the driven level.
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- CE  in  1  clock enable; all state advances only when CE=1.
- SRC_IRQ  in  NUM_SRC  source request lines.
- SRC_CLR  in  NUM_SRC  per-source pending clear pulses (software/device).
- SRC_LVL  in  4*NUM_SRC  per-source level; 0 = source disabled.
- SRC_VEC  in  8*NUM_SRC  per-source vector number.
- IRL_N  out  4  encoded level, active-low; 4'hF = none.
- VBUS_A  in  4  level being acknowledged by the CPU.
- VBUS_REQ  in  1  vector fetch request; held until the cycle after VBUS_WAIT=0.
- VBUS_DI  out  8  vector data to the CPU.
- VBUS_WAIT  out  1  stall for the vector fetch.
- BUSY  out  1  state ≠ IDLE.

## Operation
- Pending: PEND[i] is set on a rising edge of SRC_IRQ[i], detected via a registered copy of SRC_IRQ. It is cleared by SRC_CLR[i] or by a served vector fetch for source i. If a set and a clear hit the same cycle, set wins.
- Arbitration (combinational): candidate = pending source with SRC_LVL≠0 and the highest SRC_LVL. Ties go to the lowest index.
- States:
  - IDLE: IRL_N=4'hF. If a candidate exists, latch CUR_IDX/CUR_LVL → DRIVE.
  - DRIVE: IRL_N=~CUR_LVL.
    - If a candidate with level > CUR_LVL exists, relatch it (preempt) and stay in DRIVE.
    - If PEND[CUR_IDX] is cleared by SRC_CLR, go to GAP.
    - If VBUS_REQ: latch VBUS_DI = (VBUS_A==CUR_LVL) ? SRC_VEC[CUR_IDX] : SPUR_VEC and the match flag → RESP. No preemption from this point on.
  - RESP: VBUS_DI is stable and VBUS_WAIT=0. When VBUS_REQ falls: if matched, clear PEND[CUR_IDX] → GAP; if spurious → DRIVE.
  - GAP: IRL_N=4'hF and the counter loads GAP_CYC-1. When the count reaches 0 → IDLE.
- VBUS_WAIT = VBUS_REQ & (state ≠ RESP), combinational, so the CPU never samples stale data.
- VBUS_REQ seen in IDLE or GAP: respond SPUR_VEC through RESP, with no pending change.

## Timing
- Reset values: IRL_N=4'hF, VBUS_DI=8'h00, VBUS_WAIT=0 (if VBUS_REQ=0), BUSY=0, PEND=0, state IDLE, edge registers=0.
- Latency from SRC_IRQ rising to IRL_N driven: 3 CE cycles (edge register, PEND, DRIVE).
- Vector fetch:
  - REQ rises: WAIT=1 in the same cycle.
  - Next CE: state RESP, WAIT=0, VBUS_DI valid.
  - CPU drops REQ; next CE: GAP.
- Preemption does not change IRL_N until the next CE edge; IRL_N is registered and glitch-free.
- SRC_LVL/SRC_VEC are sampled at latch/RESP entry; later changes do not affect an in-flight fetch.
- RST mid-fetch: VBUS_WAIT follows the combinational rule (it will be 1 if REQ is still high, since state=IDLE), IRL_N returns to 4'hF asynchronously, and all pending is lost.

## Configuration
- IRLENC_LEVEL_SRC_EN defined: sources are level-sensitive.
  - PEND[i] = SRC_IRQ[i], with no latch.
  - SRC_CLR is ignored, and a served fetch does not clear anything; the device must drop SRC_IRQ.
  - Latency to IRL_N becomes 2 CE cycles.
  - In DRIVE, if PEND[CUR_IDX] falls, → GAP.
- Not defined: edge-latched pending as described above.

## Test plan
- SRC 2 (lvl 5, vec 8'h45) pulsed: IRL_N=4'hA after 3 CE. Fetch with VBUS_A=5 returns 8'h45 with exactly 1 WAIT cycle. IRL_N=4'hF for 6 cycles, then IDLE, PEND[2]=0.
- SRC 1 (lvl 3) and SRC 4 (lvl 9) pending together: IRL_N=4'h6 first, vec SRC_VEC[4]. After GAP, IRL_N=4'hC.
- SRC 0 (lvl 4) driven, then SRC 5 (lvl 12) edge in DRIVE: IRL_N switches 4'hB→4'h3. Fetch with VBUS_A=12 serves SRC 5, and SRC 0 remains pending.
- Fetch with VBUS_A=7 while driving lvl 4: VBUS_DI=8'h18, state returns to DRIVE, PEND unchanged.
- SRC_CLR[3] and a SRC_IRQ[3] edge in the same cycle: PEND[3]=1. SRC_CLR alone during DRIVE: IRL_N=4'hF next CE.
- RST asserted during RESP: IRL_N=4'hF immediately, VBUS_WAIT=1 while REQ is held, and the next fetch (IDLE) returns 8'h18.
